// File: rtl/cpu_pkg.sv
// Shared constants and the push/pop operation encoding for the CPU stack.
package cpu_pkg;

   localparam int DATA_W      = 8;
   localparam int STACK_DEPTH = 16;

   // Encoding matches the {push, pop} request pair so decode is a plain cast.
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      POP     = 2'b01,
      PUSH    = 2'b10,
      REPLACE = 2'b11
   } stack_op_t;

   function automatic stack_op_t decode_op(input logic push, input logic pop);
      return stack_op_t'({push, pop});
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Register-array storage for the stack: one synchronous write port and
// two asynchronous read ports. The array is deliberately not reset.
module stack_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/cpu_stack.sv
// Hardware LIFO for CPU return PCs and data words: push/pop/replace with a
// registered pop word, occupancy status and sticky overflow/underflow flags.
module cpu_stack #(
   parameter int  DATA_W = cpu_pkg::DATA_W,
   parameter int  DEPTH  = cpu_pkg::STACK_DEPTH,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   input  logic              err_clr,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic [DATA_W-1:0] top_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow
);

   import cpu_pkg::*;

   localparam int AW = $clog2(DEPTH);

   stack_op_t         op;
   logic [CNT_W-1:0]  sp;
   logic [CNT_W-1:0]  sp_dec;
   logic [AW-1:0]     top_idx;
   logic [AW-1:0]     wr_idx;
   logic              wr_en;
   logic [DATA_W-1:0] rd_top;
   logic [DATA_W-1:0] rd_pop;

   assign op      = decode_op(push, pop);
   assign sp_dec  = sp - CNT_W'(1);
   assign top_idx = sp_dec[AW-1:0];
   assign empty   = (sp == '0);
   assign full    = (sp == CNT_W'(DEPTH));
   assign count   = sp;
   assign top_data = empty ? '0 : rd_top;

   // A push writes the next free slot; a replace overwrites the current top.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = sp[AW-1:0];
      case (op)
         PUSH: begin
            wr_en = !full;
         end
         REPLACE: begin
            wr_en  = !empty;
            wr_idx = top_idx;
         end
         default: begin
         end
      endcase
   end

   stack_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk       (clk),
      .wr_en     (wr_en),
      .wr_addr   (wr_idx),
      .wr_data   (push_data),
      .rd_addr_a (top_idx),
      .rd_data_a (rd_top),
      .rd_addr_b (top_idx),
      .rd_data_b (rd_pop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
      end else begin
         case (op)
            PUSH: if (!full)  sp <= sp + CNT_W'(1);
            POP:  if (!empty) sp <= sp_dec;
            default: begin
            end
         endcase
      end
   end

   // A replace on an empty stack bypasses the array and returns push_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pop_data  <= '0;
         pop_valid <= 1'b0;
      end else begin
         pop_valid <= 1'b0;
         case (op)
            POP: begin
               if (!empty) begin
                  pop_data  <= rd_pop;
                  pop_valid <= 1'b1;
               end
            end
            REPLACE: begin
               pop_data  <= empty ? push_data : rd_pop;
               pop_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // A fresh error in the same cycle as err_clr wins over the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (overflow  & ~err_clr) | ((op == PUSH) & full);
         underflow <= (underflow & ~err_clr) | ((op == POP)  & empty);
      end
   end

endmodule
